// File: rtl/scr1_tcm_arb_if.sv
// TCM arbiter bus bundle: core imem/dmem request ports plus the single-port memory side.
// The package carries the shared memory command/width/response encodings.
package scr1_tcm_arb_pkg;
    localparam int SCR1_IMEM_AWIDTH = 32;
    localparam int SCR1_DMEM_AWIDTH = 32;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;
endpackage

interface scr1_tcm_arb_if #(
    parameter logic [31:0] SCR1_TCM_SIZE = 32'h00010000
);
    import scr1_tcm_arb_pkg::*;
    localparam int AW = $clog2(SCR1_TCM_SIZE) - 2;

    logic                          imem_req;
    type_scr1_mem_cmd_e            imem_cmd;
    logic [SCR1_IMEM_AWIDTH-1:0]   imem_addr;
    logic                          imem_req_ack;
    logic [31:0]                   imem_rdata;
    type_scr1_mem_resp_e           imem_resp;

    logic                          dmem_req;
    type_scr1_mem_cmd_e            dmem_cmd;
    type_scr1_mem_width_e          dmem_width;
    logic [SCR1_DMEM_AWIDTH-1:0]   dmem_addr;
    logic [31:0]                   dmem_wdata;
    logic                          dmem_req_ack;
    logic [31:0]                   dmem_rdata;
    type_scr1_mem_resp_e           dmem_resp;

    logic                          mem_rena;
    logic                          mem_wena;
    logic [3:0]                    mem_byteen;
    logic [AW-1:0]                 mem_addr;
    logic [31:0]                   mem_wdata;
    logic [31:0]                   mem_rdata;

    modport master (
        output imem_req, imem_cmd, imem_addr,
        input  imem_req_ack, imem_rdata, imem_resp,
        output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        input  dmem_req_ack, dmem_rdata, dmem_resp,
        input  mem_rena, mem_wena, mem_byteen, mem_addr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  imem_req, imem_cmd, imem_addr,
        output imem_req_ack, imem_rdata, imem_resp,
        input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        output dmem_req_ack, dmem_rdata, dmem_resp,
        output mem_rena, mem_wena, mem_byteen, mem_addr, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/scr1_tcm_arb.sv
// Single-port TCM arbiter: imem/dmem grant, byte-lane steering, range check, responses.
// Optional dmem burst limit enabled by defining SCR1_TCM_ARB_BURST_LIMIT_EN.
module scr1_tcm_arb
    import scr1_tcm_arb_pkg::*;
#(
    parameter logic [31:0] SCR1_TCM_SIZE      = 32'h00010000,
    parameter int          SCR1_TCM_ARB_BURST = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    scr1_tcm_arb_if.slave  bus
);
    localparam int AW = $clog2(SCR1_TCM_SIZE) - 2;

    logic                rdy_q;
    logic                i_pri;
    logic                i_gnt;
    logic                d_gnt;
    logic                i_err;
    logic                d_err;
    logic                d_mis;
    logic                d_rd;
    type_scr1_mem_resp_e i_resp_q, i_resp_d;
    type_scr1_mem_resp_e d_resp_q, d_resp_d;
    logic [1:0]          shift_q, shift_d;
    logic                d_rd_q, d_rd_d;
    logic                rena;
    logic                wena;
    logic [3:0]          byteen;
    logic [AW-1:0]       maddr;
    logic [31:0]         wdata;
    logic                unused_ok;

    assign unused_ok = ^{bus.imem_cmd, bus.imem_addr[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_q <= 1'b0;
        else        rdy_q <= 1'b1;
    end

    assign d_rd  = (bus.dmem_cmd == SCR1_MEM_CMD_RD);
    assign i_err = (bus.imem_addr >= SCR1_TCM_SIZE);

    always_comb begin
        d_mis = 1'b0;
        case (bus.dmem_width)
            SCR1_MEM_WIDTH_BYTE:  d_mis = 1'b0;
            SCR1_MEM_WIDTH_HWORD: d_mis = bus.dmem_addr[0];
            SCR1_MEM_WIDTH_WORD:  d_mis = |bus.dmem_addr[1:0];
            default:              d_mis = 1'b1;
        endcase
    end

    assign d_err = (bus.dmem_addr >= SCR1_TCM_SIZE) | d_mis;

`ifdef SCR1_TCM_ARB_BURST_LIMIT_EN
    logic [3:0] burst_q, burst_d;

    // imem takes the port once dmem has held it for the burst budget
    assign i_pri = bus.imem_req & (burst_q >= 4'(SCR1_TCM_ARB_BURST));

    always_comb begin
        burst_d = burst_q;
        if (!bus.imem_req || i_gnt)   burst_d = 4'd0;
        else if (d_gnt && burst_q != 4'hF) burst_d = burst_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) burst_q <= 4'd0;
        else        burst_q <= burst_d;
    end
`else
    assign i_pri = 1'b0;
`endif

    assign d_gnt = rdy_q & bus.dmem_req & ~i_pri;
    assign i_gnt = rdy_q & bus.imem_req & ~d_gnt;

    always_comb begin
        rena   = 1'b0;
        wena   = 1'b0;
        byteen = 4'h0;
        maddr  = '0;
        wdata  = 32'h0;
        if (d_gnt) begin
            maddr = bus.dmem_addr[AW+1:2];
            if (!d_err) begin
                rena = d_rd;
                wena = ~d_rd;
                case (bus.dmem_width)
                    SCR1_MEM_WIDTH_BYTE: begin
                        byteen = 4'b0001 << bus.dmem_addr[1:0];
                        wdata  = {4{bus.dmem_wdata[7:0]}};
                    end
                    SCR1_MEM_WIDTH_HWORD: begin
                        byteen = 4'b0011 << {bus.dmem_addr[1], 1'b0};
                        wdata  = {2{bus.dmem_wdata[15:0]}};
                    end
                    default: begin
                        byteen = 4'hF;
                        wdata  = bus.dmem_wdata;
                    end
                endcase
            end
        end else if (i_gnt) begin
            maddr = bus.imem_addr[AW+1:2];
            if (!i_err) begin
                rena   = 1'b1;
                byteen = 4'hF;
            end
        end
    end

    always_comb begin
        i_resp_d = SCR1_MEM_RESP_NOTRDY;
        d_resp_d = SCR1_MEM_RESP_NOTRDY;
        shift_d  = shift_q;
        d_rd_d   = d_rd_q;
        if (i_gnt) begin
            i_resp_d = i_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
        end
        if (d_gnt) begin
            d_resp_d = d_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
            shift_d  = bus.dmem_addr[1:0];
            d_rd_d   = d_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_resp_q <= SCR1_MEM_RESP_NOTRDY;
            d_resp_q <= SCR1_MEM_RESP_NOTRDY;
            shift_q  <= 2'd0;
            d_rd_q   <= 1'b0;
        end else begin
            i_resp_q <= i_resp_d;
            d_resp_q <= d_resp_d;
            shift_q  <= shift_d;
            d_rd_q   <= d_rd_d;
        end
    end

    assign bus.imem_req_ack = i_gnt;
    assign bus.dmem_req_ack = d_gnt;
    assign bus.mem_rena     = rena;
    assign bus.mem_wena     = wena;
    assign bus.mem_byteen   = byteen;
    assign bus.mem_addr     = maddr;
    assign bus.mem_wdata    = wdata;
    assign bus.imem_resp    = i_resp_q;
    assign bus.dmem_resp    = d_resp_q;

    assign bus.imem_rdata = (i_resp_q == SCR1_MEM_RESP_RDY_OK) ? bus.mem_rdata : 32'h0;
    assign bus.dmem_rdata = (d_resp_q == SCR1_MEM_RESP_RDY_OK && d_rd_q)
                          ? (bus.mem_rdata >> {shift_q, 3'b000}) : 32'h0;
endmodule

// File: tb/tb_scr1_tcm_arb.sv
// Randomized bench for scr1_tcm_arb with a byte-level memory model and grant rules.
// Directed sequences pin reset release, byte steering, range errors and contention.
module tb_scr1_tcm_arb;
    import scr1_tcm_arb_pkg::*;

    localparam logic [31:0] TCM   = 32'h400;
    localparam int          BURST = 4;
    localparam int          NW    = 256;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    scr1_tcm_arb_if #(.SCR1_TCM_SIZE(TCM)) bus();

    scr1_tcm_arb #(
        .SCR1_TCM_SIZE(TCM),
        .SCR1_TCM_ARB_BURST(BURST)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // Memory macro stand-in: one-cycle read latency, byte-enabled writes
    logic [31:0] bmem [NW];
    logic [31:0] rdq;
    always @(posedge clk) begin
        if (bus.mem_wena)
            for (int k = 0; k < 4; k++)
                if (bus.mem_byteen[k])
                    bmem[bus.mem_addr][8*k +: 8] <= bus.mem_wdata[8*k +: 8];
        if (bus.mem_rena) rdq <= bmem[bus.mem_addr];
    end
    assign bus.mem_rdata = rdq;

    // Reference model state
    logic [7:0]          shadow [int];
    bit                  mrdy;
    int                  streak;
    type_scr1_mem_resp_e pend_i, pend_d;
    logic [31:0]         pend_idata, pend_ddata;
    bit                  m_ig, m_dg;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int wsize(type_scr1_mem_width_e w);
        case (w)
            SCR1_MEM_WIDTH_BYTE:  return 1;
            SCR1_MEM_WIDTH_HWORD: return 2;
            default:              return 4;
        endcase
    endfunction

    function automatic logic [31:0] sh_word(logic [31:0] a);
        logic [31:0] base;
        base = a & ~32'h3;
        return {shadow[base+3], shadow[base+2], shadow[base+1], shadow[base]};
    endfunction

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cycle();
        bit ig, dg, ierr, derr, drd, erena, ewena, ipri;
        int ds;
        logic [31:0] da, ew;
        @(negedge clk);
        if (!rst_n) begin
            check("rst_iresp", 32'(bus.imem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
            check("rst_dresp", 32'(bus.dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
            check("rst_irdata", bus.imem_rdata, 0);
            check("rst_drdata", bus.dmem_rdata, 0);
            check("rst_iack", 32'(bus.imem_req_ack), 0);
            check("rst_dack", 32'(bus.dmem_req_ack), 0);
            check("rst_rena", 32'(bus.mem_rena), 0);
            check("rst_wena", 32'(bus.mem_wena), 0);
            pend_i = SCR1_MEM_RESP_NOTRDY;
            pend_d = SCR1_MEM_RESP_NOTRDY;
            pend_idata = 0;
            pend_ddata = 0;
            streak = 0;
            mrdy = 0;
            m_ig = 0;
            m_dg = 0;
            return;
        end
        check("imem_resp", 32'(bus.imem_resp), 32'(pend_i));
        check("imem_rdata", bus.imem_rdata,
              pend_i == SCR1_MEM_RESP_RDY_OK ? pend_idata : 32'h0);
        check("dmem_resp", 32'(bus.dmem_resp), 32'(pend_d));
        check("dmem_rdata", bus.dmem_rdata,
              pend_d == SCR1_MEM_RESP_RDY_OK ? pend_ddata : 32'h0);

`ifdef SCR1_TCM_ARB_BURST_LIMIT_EN
        ipri = bus.imem_req && streak >= BURST;
`else
        ipri = 0;
`endif
        dg = mrdy && bus.dmem_req && !ipri;
        ig = mrdy && bus.imem_req && !dg;
        da = bus.dmem_addr;
        ds = wsize(bus.dmem_width);
        drd = (bus.dmem_cmd == SCR1_MEM_CMD_RD);
        ierr = bus.imem_addr >= TCM;
        derr = (da >= TCM) || ((da % ds) != 0);
        erena = (ig && !ierr) || (dg && !derr && drd);
        ewena = dg && !derr && !drd;

        check("imem_ack", 32'(bus.imem_req_ack), 32'(ig));
        check("dmem_ack", 32'(bus.dmem_req_ack), 32'(dg));
        check("mem_rena", 32'(bus.mem_rena), 32'(erena));
        check("mem_wena", 32'(bus.mem_wena), 32'(ewena));
        if (ig && !ierr) check("imem_maddr", 32'(bus.mem_addr), bus.imem_addr / 4);
        if (dg && !derr) check("dmem_maddr", 32'(bus.mem_addr), da / 4);
        if (ewena) begin
            for (int k = 0; k < 4; k++)
                ew[8*k +: 8] = 8'(bus.dmem_wdata >> (8 * (k % ds)));
            check("mem_byteen", 32'(bus.mem_byteen),
                  32'(((1 << ds) - 1) << (da % 4)) & 32'hF);
            check("mem_wdata", bus.mem_wdata, ew);
        end

        pend_i = !ig ? SCR1_MEM_RESP_NOTRDY :
                 ierr ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
        pend_idata = (ig && !ierr) ? sh_word(bus.imem_addr) : 32'h0;
        pend_d = !dg ? SCR1_MEM_RESP_NOTRDY :
                 derr ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
        pend_ddata = (dg && !derr && drd) ? (sh_word(da) >> (8 * (da % 4))) : 32'h0;
        if (ewena)
            for (int j = 0; j < ds; j++)
                shadow[da + j] = 8'(bus.dmem_wdata >> (8 * j));
        if (!bus.imem_req || ig) streak = 0;
        else if (dg && streak < 15) streak++;
        mrdy = 1;
        m_ig = ig;
        m_dg = dg;
    endtask

    task automatic set_d(type_scr1_mem_cmd_e c, type_scr1_mem_width_e w,
                         logic [31:0] a, logic [31:0] d);
        bus.dmem_req   = 1'b1;
        bus.dmem_cmd   = c;
        bus.dmem_width = w;
        bus.dmem_addr  = a;
        bus.dmem_wdata = d;
    endtask

    task automatic contention(string tag);
        logic [9:0] seq, exp;
        bus.imem_req  = 1'b1;
        bus.imem_addr = 32'h20;
        set_d(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h40, 0);
        for (int i = 0; i < 10; i++) begin
            chk_cycle();
            seq[i] = bus.imem_req_ack;
            adv();
        end
`ifdef SCR1_TCM_ARB_BURST_LIMIT_EN
        exp = 10'h210;
`else
        exp = 10'h000;
`endif
        check({tag, "_seq"}, 32'(seq), 32'(exp));
        bus.dmem_req = 1'b0;
        chk_cycle();
        check({tag, "_lone_i"}, 32'(bus.imem_req_ack), 1);
        adv();
        bus.imem_req = 1'b0;
    endtask

    task automatic rand_inputs();
        int r, ds;
        logic [31:0] a;
        if (!(bus.imem_req && !m_ig)) begin
            bus.imem_req  = $urandom_range(0, 99) < 60;
            bus.imem_addr = ($urandom_range(0, 99) < 5)
                          ? TCM + 4 * $urandom_range(0, 15)
                          : 32'($urandom_range(0, NW - 1)) * 4;
        end
        if (!(bus.dmem_req && !m_dg)) begin
            bus.dmem_req   = $urandom_range(0, 99) < 60;
            bus.dmem_cmd   = type_scr1_mem_cmd_e'($urandom_range(0, 1));
            bus.dmem_width = type_scr1_mem_width_e'(2'($urandom_range(0, 2)));
            bus.dmem_wdata = $urandom;
            ds = wsize(bus.dmem_width);
            r = $urandom_range(0, 99);
            if (r < 5) a = TCM + $urandom_range(0, 63);
            else if (r < 60) a = $urandom_range(0, 63);
            else a = $urandom_range(0, TCM - 1);
            if (r >= 15) a = a & ~32'(ds - 1);
            bus.dmem_addr = a;
        end
    endtask

    initial begin
        logic [31:0] w;
        for (int i = 0; i < NW; i++) begin
            w = (i == 4) ? 32'hCAFE0010 : $urandom;
            bmem[i] = w;
            for (int j = 0; j < 4; j++) shadow[4*i + j] = w[8*j +: 8];
        end
        mrdy = 0;
        streak = 0;
        pend_i = SCR1_MEM_RESP_NOTRDY;
        pend_d = SCR1_MEM_RESP_NOTRDY;
        pend_idata = 0;
        pend_ddata = 0;
        m_ig = 0;
        m_dg = 0;
        bus.imem_req   = 1'b1;
        bus.imem_cmd   = SCR1_MEM_CMD_RD;
        bus.imem_addr  = 32'h10;
        bus.dmem_req   = 1'b0;
        bus.dmem_cmd   = SCR1_MEM_CMD_RD;
        bus.dmem_width = SCR1_MEM_WIDTH_WORD;
        bus.dmem_addr  = 0;
        bus.dmem_wdata = 0;

        // Reset release with a fetch held from reset
        chk_cycle();
        check("rst_ack_lit", 32'(bus.imem_req_ack), 0);
        adv();
        rst_n = 1'b1;
        chk_cycle();
        check("rel_c1_ack", 32'(bus.imem_req_ack), 0);
        adv();
        chk_cycle();
        check("rel_c2_ack", 32'(bus.imem_req_ack), 1);
        adv();
        bus.imem_req = 1'b0;
        chk_cycle();
        check("rel_resp", 32'(bus.imem_resp), 32'(SCR1_MEM_RESP_RDY_OK));
        check("rel_data", bus.imem_rdata, 32'hCAFE0010);
        adv();

        // Byte write then read-back of the same word
        set_d(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h102, 32'hAB);
        chk_cycle();
        check("bw_byteen", 32'(bus.mem_byteen), 32'b0100);
        check("bw_wdata", bus.mem_wdata, 32'hABABABAB);
        adv();
        set_d(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h102, 0);
        chk_cycle();
        check("bw_wr_rdata", bus.dmem_rdata, 0);
        adv();
        bus.dmem_req = 1'b0;
        chk_cycle();
        check("br_resp", 32'(bus.dmem_resp), 32'(SCR1_MEM_RESP_RDY_OK));
        check("br_byte", 32'(bus.dmem_rdata[7:0]), 32'hAB);
        adv();

        // Out of range, then misaligned word
        set_d(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, TCM + 4, 0);
        chk_cycle();
        check("oor_ack", 32'(bus.dmem_req_ack), 1);
        check("oor_rena", 32'(bus.mem_rena), 0);
        adv();
        set_d(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h2, 0);
        chk_cycle();
        check("oor_resp", 32'(bus.dmem_resp), 32'(SCR1_MEM_RESP_RDY_ER));
        adv();
        bus.dmem_req = 1'b0;
        chk_cycle();
        check("mis_resp", 32'(bus.dmem_resp), 32'(SCR1_MEM_RESP_RDY_ER));
        adv();

        contention("cont1");
        chk_cycle();
        adv();

        // Reset dropped in a dmem grant cycle after a partial burst
        bus.imem_req  = 1'b1;
        bus.imem_addr = 32'h20;
        set_d(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h40, 0);
        chk_cycle();
        adv();
        chk_cycle();
        adv();
        #1 rst_n = 1'b0;
        chk_cycle();
        check("midrst_resp", 32'(bus.dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
        adv();
        rst_n = 1'b1;
        chk_cycle();
        check("midrst_rel_resp", 32'(bus.dmem_resp), 32'(SCR1_MEM_RESP_NOTRDY));
        check("midrst_rel_ack", 32'(bus.dmem_req_ack), 0);
        adv();
        contention("cont2");

        // Random traffic with one reset pulse in the middle
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        m_ig = 0;
        m_dg = 0;
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            if (i == 1500) rst_n = 1'b0;
            if (i == 1502) rst_n = 1'b1;
            chk_cycle();
            adv();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
